// File: rtl/pipe_pkg.sv
// pipe_pkg -- constants and types shared by the pipeline-stage register.
//   INST_LEN    : PC / instruction field width, taken from `INST_LEN
//                 (constants.sv is its source; the fallback only covers a
//                 compile order where this package is read first)
//   PIPE_DATA_W : payload width, one PC plus one instruction
//   if_id_t     : packed {pc, instr} payload
//   PIPE_NOP    : all-zero payload, the NOP encoding
//   PIPE_BUBBLE : default value loaded on reset or flush
`ifndef INST_LEN
`define INST_LEN 16
`endif

package pipe_pkg;

    localparam int INST_LEN    = `INST_LEN;
    localparam int PIPE_DATA_W = 2 * INST_LEN;

    typedef struct packed {
        logic [INST_LEN-1:0] pc;
        logic [INST_LEN-1:0] instr;
    } if_id_t;

    localparam logic [INST_LEN-1:0] NOP_INSTR = '0;

    localparam if_id_t PIPE_NOP_ST = '{pc: '0, instr: NOP_INSTR};

    localparam logic [PIPE_DATA_W-1:0] PIPE_NOP    = PIPE_NOP_ST;
    localparam logic [PIPE_DATA_W-1:0] PIPE_BUBBLE = PIPE_NOP;

endpackage

// File: rtl/constants.sv
// Shared instruction-set constants.
// INST_LEN : width of one PC or one instruction word. The pipeline payload
//            carries one of each, so the default payload is 2*INST_LEN bits.
`ifndef INST_LEN
`define INST_LEN 16
`endif

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf -- one-entry skid register for pipe_stage_reg.
// Only exists in the PIPE_SKID_EN build.
// Ports:
//   clk        : clock, rising edge
//   srst       : synchronous active-high reset (empties the entry)
//   flush      : synchronous squash of the entry (below srst in priority)
//   push       : capture push_data (only asserted while the entry is empty)
//   push_data  : payload to capture
//   pop        : entry is being moved into the main register
//   skid_valid : entry holds data
//   skid_data  : held payload
//   ready      : registered "entry empty", the stage's upstream ready
`ifdef PIPE_SKID_EN
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              skid_valid,
    output logic [DATA_W-1:0] skid_data,
    output logic              ready
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              ready_q, ready_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (push) begin
            valid_d = 1'b1;
            data_d  = push_data;
        end else if (pop) begin
            valid_d = 1'b0;
        end
        // Ready is the next-state emptiness, so it comes straight off a flop.
        ready_d = !valid_d;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ready_q <= ready_d;
        end
    end

    assign skid_valid = valid_q;
    assign skid_data  = data_q;
    assign ready      = ready_q;

endmodule
`endif

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- valid/ready pipeline register with flush and stall count.
// Build option: define PIPE_SKID_EN to add a one-entry skid register
// (pipe_skid_buf) and a registered in_ready; without it in_ready is
// combinational from out_ready.
// Ports:
//   clk       : clock, rising edge
//   Reset     : synchronous active-high reset (highest priority)
//   Flush     : synchronous squash of all held entries, loads BUBBLE
//   in_valid  / in_ready / in_data   : upstream handshake and payload
//   out_valid / out_ready / out_data : downstream handshake and payload
//   stall_cnt : saturating count of cycles with out_valid=1, out_ready=0
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W = PIPE_DATA_W,
    parameter logic [DATA_W-1:0] BUBBLE = DATA_W'(PIPE_BUBBLE),
    parameter int                CNT_W  = 16
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              Flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic              ready_base;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic              stalled;
    logic              deliver;
    logic              accept;

    assign stalled = out_valid_q && !out_ready;
    assign deliver = out_valid_q && out_ready;

    // Reset and Flush gate ready so nothing is accepted in a cycle whose
    // data would be thrown away anyway.
    assign in_ready = ready_base && !Reset && !Flush;
    assign accept   = in_valid && in_ready;

`ifdef PIPE_SKID_EN
    logic skid_push;
    logic skid_pop;

    // A word accepted while main is held goes to the skid entry; the skid
    // entry refills main as soon as main delivers, preserving order.
    assign skid_push = accept && stalled;
    assign skid_pop  = deliver && skid_valid;

    pipe_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk        (clk),
        .srst       (Reset),
        .flush      (Flush),
        .push       (skid_push),
        .push_data  (in_data),
        .pop        (skid_pop),
        .skid_valid (skid_valid),
        .skid_data  (skid_data),
        .ready      (ready_base)
    );
`else
    assign skid_valid = 1'b0;
    assign skid_data  = BUBBLE;
    assign ready_base = !out_valid_q || out_ready;
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        stall_cnt_d = stall_cnt_q;

        // Saturating stall counter; Flush leaves it alone.
        if (stalled && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        if (Flush) begin
            out_valid_d = 1'b0;
            out_data_d  = BUBBLE;
        end else if (deliver && skid_valid) begin
            out_valid_d = 1'b1;
            out_data_d  = skid_data;
        end else if (accept && !stalled) begin
            // Covers both an empty main and deliver+accept on the same edge.
            out_valid_d = 1'b1;
            out_data_d  = in_data;
        end else if (deliver) begin
            // Data is left in place; only the valid bit drops.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= BUBBLE;
            stall_cnt_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    localparam int              DW  = 32;
    localparam logic [DW-1:0]   BUB = 32'h0000_0013;
`ifdef PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          Reset, Flush, in_valid, out_ready;
    logic [DW-1:0] in_data;

    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
    logic [15:0]   stall_cnt;

    logic          in_ready_s, out_valid_s;
    logic [DW-1:0] out_data_s;
    logic [3:0]    stall_cnt_s;

    pipe_stage_reg #(.DATA_W(DW), .BUBBLE(BUB), .CNT_W(16)) dut (
        .clk(clk), .Reset(Reset), .Flush(Flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.DATA_W(DW), .BUBBLE(BUB), .CNT_W(4)) dut_sat (
        .clk(clk), .Reset(Reset), .Flush(Flush),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
        .stall_cnt(stall_cnt_s)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the stage as an ordered queue of held words.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_shown;
    int            m_stall;
    bit            verbose;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic f, input logic iv,
                        input logic [DW-1:0] d, input logic ordy);
        logic          exp_rdy;
        logic [DW-1:0] delivered;
        bit            did_del;
        int            e16, e4;
        Reset = r; Flush = f; in_valid = iv; in_data = d; out_ready = ordy;
        #1;
        if (r || f)    exp_rdy = 1'b0;
        else if (SKID) exp_rdy = (mq.size() < 2);
        else           exp_rdy = (mq.size() == 0) || ordy;
        check("in_ready",     32'(in_ready),   32'(exp_rdy));
        check("in_ready_sat", 32'(in_ready_s), 32'(exp_rdy));

        if (mq.size() != 0 && !ordy) m_stall++;
        did_del   = 1'b0;
        delivered = '0;
        if (r) begin
            mq.delete();
            m_shown = BUB;
            m_stall = 0;
        end else if (f) begin
            mq.delete();
            m_shown = BUB;
        end else begin
            if (mq.size() != 0 && ordy) begin
                delivered = mq.pop_front();
                did_del   = 1'b1;
            end
            if (iv && exp_rdy) mq.push_back(d);
            if (mq.size() != 0) m_shown = mq[0];
        end

        @(posedge clk);
        #1;
        e16 = (m_stall > 65535) ? 65535 : m_stall;
        e4  = (m_stall > 15) ? 15 : m_stall;
        check("out_valid",     32'(out_valid),   32'(mq.size() != 0));
        check("out_data",      out_data,         m_shown);
        check("stall_cnt",     32'(stall_cnt),   32'(e16));
        check("out_valid_sat", 32'(out_valid_s), 32'(mq.size() != 0));
        check("out_data_sat",  out_data_s,       m_shown);
        check("stall_cnt_sat", 32'(stall_cnt_s), 32'(e4));
        if (verbose && did_del) $display("deliver data=%08h stall_cnt=%0d", delivered, stall_cnt);
    endtask

    initial begin
        Reset = 1'b1; Flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        m_shown = BUB; m_stall = 0; verbose = 1'b1;

        // Reset state
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        check("rst_out_data", out_data, BUB);

        // Streaming 1..16
        for (int i = 1; i <= 16; i++) step(0, 0, 1, DW'(i), 1);
        check("stream_last", out_data, 32'h10);
        step(0, 0, 0, 0, 1);
        check("stream_stall", 32'(stall_cnt), 32'd0);

        // Backpressure
        step(1, 0, 0, 0, 1);
        step(0, 0, 1, 32'hAAAA, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 32'hBBBB, 0);
        check("bp_hold", out_data, 32'hAAAA);
        check("bp_stall", 32'(stall_cnt), 32'd5);
        step(0, 0, 0, 0, 1);
        check("bp_next", out_data, SKID ? 32'hBBBB : 32'hAAAA);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        // Flush with main (and skid, if present) occupied
        step(1, 0, 0, 0, 1);
        step(0, 0, 1, 32'h1234, 1);
        step(0, 0, 1, 32'h9999, 0);
        step(0, 1, 1, 32'h5678, 0);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_data", out_data, BUB);
        Flush = 1'b0; in_valid = 1'b0; #1;
        check("flush_rdy_after", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);

        // Reset in the middle of a stall
        step(1, 0, 0, 0, 1);
        step(0, 0, 1, 32'h7777, 1);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0);
        check("mid_stall", 32'(stall_cnt), 32'd7);
        step(1, 0, 1, 32'hCAFE, 0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data", out_data, BUB);
        check("mid_rst_cnt", 32'(stall_cnt), 32'd0);
        step(0, 0, 0, 0, 1);

        // Saturation of the 4-bit counter
        step(0, 0, 1, 32'h5A5A, 1);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0);
        check("sat_4bit", 32'(stall_cnt_s), 32'd15);
        check("sat_16bit", 32'(stall_cnt), 32'd20);
        step(0, 0, 0, 0, 1);

        // Random traffic
        verbose = 1'b0;
        step(1, 0, 0, 0, 1);
        for (int i = 0; i < 10000; i++) begin
            step($urandom_range(0, 511) == 0, $urandom_range(0, 63) == 0,
                 $urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 2) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
